// File: rtl/fu_completion_arbiter_if.sv
// Completion bus between the functional units, the arbiter and the ROB write ports.
// The arbiter takes the slave side; the FU/ROB environment takes the master side.
interface fu_completion_arbiter_if #(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int CPL_PORTS    = 2
);
  logic                                     flush;
  logic [FU_COUNT-1:0]                      fu_valid;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]    fu_inst_id;
  logic [FU_COUNT-1:0]                      fu_ready;
  logic [CPL_PORTS-1:0]                     rob_cpl_valid;
  logic [CPL_PORTS-1:0][INST_ID_BITS-1:0]   rob_cpl_id;
  logic [15:0]                              stall_cycles;

  modport master (
    output flush, fu_valid, fu_inst_id,
    input  fu_ready, rob_cpl_valid, rob_cpl_id, stall_cycles
  );

  modport slave (
    input  flush, fu_valid, fu_inst_id,
    output fu_ready, rob_cpl_valid, rob_cpl_id, stall_cycles
  );
endinterface

// File: rtl/fu_completion_arbiter.sv
// Round-robin arbiter granting up to CPL_PORTS FU completions per cycle onto the ROB
// write ports, with a saturating counter of cycles in which some FU was left waiting.
module fu_completion_arbiter #(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int CPL_PORTS    = 2
) (
  input logic                    clk,
  input logic                    rst,
  fu_completion_arbiter_if.slave bus
);
  localparam int PTR_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic [PTR_BITS-1:0]                    r_rrPtr;
  logic [CPL_PORTS-1:0]                   r_cplValid;
  logic [CPL_PORTS-1:0][INST_ID_BITS-1:0] r_cplId;
  logic [15:0]                            r_stallCycles;

  logic [FU_COUNT-1:0]                    w_ready;
  logic [CPL_PORTS-1:0]                   w_portValid;
  logic [CPL_PORTS-1:0][INST_ID_BITS-1:0] w_portId;
  logic [PTR_BITS-1:0]                    w_lastIdx;
  logic [PTR_BITS-1:0]                    w_scanIdx;
  logic [PTR_BITS-1:0]                    w_nextPtr;
  logic                                   w_found;
  logic                                   w_block;
  logic                                   w_stall;
  int                                     w_scanPos;

  // Port k takes the first still-unselected valid FU in scan order starting at r_rrPtr.
  always_comb begin
    w_ready     = '0;
    w_portValid = '0;
    w_portId    = '0;
    w_lastIdx   = r_rrPtr;
    w_scanIdx   = r_rrPtr;
    w_scanPos   = 0;
    w_found     = 1'b0;
    w_block     = rst | bus.flush;
    for (int k = 0; k < CPL_PORTS; k++) begin
      w_found = 1'b0;
      for (int j = 0; j < FU_COUNT; j++) begin
        w_scanPos = int'(r_rrPtr) + j;
        if (w_scanPos >= FU_COUNT) w_scanPos = w_scanPos - FU_COUNT;
        w_scanIdx = PTR_BITS'(w_scanPos);
        if (!w_block && !w_found && bus.fu_valid[w_scanIdx] && !w_ready[w_scanIdx]) begin
          w_found              = 1'b1;
          w_ready[w_scanIdx]   = 1'b1;
          w_portValid[k]       = 1'b1;
          w_portId[k]          = bus.fu_inst_id[w_scanIdx];
          w_lastIdx            = w_scanIdx;
        end
      end
    end
  end

  always_comb begin
    w_nextPtr = (int'(w_lastIdx) == FU_COUNT - 1) ? '0 : w_lastIdx + 1'b1;
    w_stall   = |(bus.fu_valid & ~w_ready);
  end

  // Flush drops the in-flight grant and restarts the scan at FU0 but keeps the stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr       <= '0;
      r_cplValid    <= '0;
      r_cplId       <= '0;
      r_stallCycles <= '0;
    end else if (bus.flush) begin
      r_rrPtr    <= '0;
      r_cplValid <= '0;
    end else begin
      r_cplValid <= w_portValid;
      r_cplId    <= w_portId;
      if (|w_portValid) r_rrPtr <= w_nextPtr;
      if (w_stall && (r_stallCycles != 16'hFFFF)) r_stallCycles <= r_stallCycles + 16'd1;
    end
  end

  assign bus.fu_ready      = w_ready;
  assign bus.rob_cpl_valid = r_cplValid;
  assign bus.rob_cpl_id    = r_cplId;
  assign bus.stall_cycles  = r_stallCycles;
endmodule

// File: tb/tb_fu_completion_arbiter.sv
// Directed bench for fu_completion_arbiter: a queue-based scan model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fu_completion_arbiter;
  localparam int ID = 6;
  localparam int FU = 4;
  localparam int CP = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fu_completion_arbiter_if #(.INST_ID_BITS(ID), .FU_COUNT(FU), .CPL_PORTS(CP)) bus ();

  fu_completion_arbiter #(.INST_ID_BITS(ID), .FU_COUNT(FU), .CPL_PORTS(CP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [FU-1:0] valid, input logic [FU-1:0][ID-1:0] ids);
    bus.fu_valid   = valid;
    bus.fu_inst_id = ids;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: pointer, registered port contents, stall count
  int                   mPtr   = 0;
  int                   mStall = 0;
  logic [CP-1:0]        mValid = '0;
  logic [CP-1:0][ID-1:0] mId   = '0;
  bit                   mLive  = 1'b0;
  int                   nPtr, nStall;
  logic [CP-1:0]        nValid;
  logic [CP-1:0][ID-1:0] nId;
  bit                   nLive;
  logic [FU-1:0]        mReady;
  int                   sel[$];

  // Model: list the valid FUs in priority order, the first CP of them win
  always @(negedge clk) begin
    sel.delete();
    mReady = '0;
    if (!(rst || bus.flush)) begin
      for (int j = 0; j < FU; j++) begin
        int idx;
        idx = (mPtr + j) % FU;
        if (bus.fu_valid[idx] && sel.size() < CP) begin
          sel.push_back(idx);
          mReady[idx] = 1'b1;
        end
      end
    end
    if (mLive) begin
      checkOutput("fu_ready", 32'(bus.fu_ready), 32'(mReady));
      checkOutput("rob_cpl_valid", 32'(bus.rob_cpl_valid), 32'(mValid));
      checkOutput("stall_cycles", 32'(bus.stall_cycles), 32'(mStall));
      for (int k = 0; k < CP; k++)
        if (mValid[k]) checkOutput($sformatf("rob_cpl_id%0d", k), 32'(bus.rob_cpl_id[k]), 32'(mId[k]));
    end
    nValid = '0;
    nId    = '0;
    nPtr   = mPtr;
    nStall = mStall;
    nLive  = mLive;
    if (rst) begin
      nPtr   = 0;
      nStall = 0;
      nLive  = 1'b1;
    end else if (bus.flush) begin
      nPtr = 0;
    end else begin
      for (int k = 0; k < sel.size(); k++) begin
        nValid[k] = 1'b1;
        nId[k]    = bus.fu_inst_id[sel[k]];
      end
      if (sel.size() > 0) nPtr = (sel[sel.size()-1] + 1) % FU;
      if (((bus.fu_valid & ~mReady) != '0) && nStall < 65535) nStall++;
    end
  end

  always @(posedge clk) begin
    mPtr   = nPtr;
    mStall = nStall;
    mValid = nValid;
    mId    = nId;
    mLive  = nLive;
  end

  initial begin
    int guard;
    rst       = 1'b1;
    bus.flush = 1'b0;
    applyStimulus('0, '0);
    repeat (2) tick();
    rst = 1'b0;

    // Idle after reset
    repeat (5) tick();
    @(negedge clk);
    checkOutput("idle_ready", 32'(bus.fu_ready), 32'h0);
    checkOutput("idle_valid", 32'(bus.rob_cpl_valid), 32'h0);
    checkOutput("idle_stall", 32'(bus.stall_cycles), 32'h0);

    // All four valid, two ports: FU0/FU1 then FU2/FU3
    tick();
    applyStimulus(4'b1111, {6'd13, 6'd12, 6'd11, 6'd10});
    @(negedge clk);
    checkOutput("rr_first_ready", 32'(bus.fu_ready), 32'h3);
    tick();
    applyStimulus(4'b1100, {6'd13, 6'd12, 6'd11, 6'd10});
    @(negedge clk);
    checkOutput("rr_second_ready", 32'(bus.fu_ready), 32'hC);
    checkOutput("rr_first_valid", 32'(bus.rob_cpl_valid), 32'h3);
    checkOutput("rr_first_id0", 32'(bus.rob_cpl_id[0]), 32'd10);
    checkOutput("rr_first_id1", 32'(bus.rob_cpl_id[1]), 32'd11);
    tick();
    applyStimulus('0, '0);
    @(negedge clk);
    checkOutput("rr_second_id0", 32'(bus.rob_cpl_id[0]), 32'd12);
    checkOutput("rr_second_id1", 32'(bus.rob_cpl_id[1]), 32'd13);
    checkOutput("rr_stall", 32'(bus.stall_cycles), 32'd1);

    // Lone requester FU2 with pointer at 0
    tick();
    applyStimulus(4'b0100, {6'd0, 6'd7, 6'd0, 6'd0});
    @(negedge clk);
    checkOutput("single_ready", 32'(bus.fu_ready), 32'h4);
    tick();
    applyStimulus('0, '0);
    @(negedge clk);
    checkOutput("single_valid", 32'(bus.rob_cpl_valid), 32'h1);
    checkOutput("single_id0", 32'(bus.rob_cpl_id[0]), 32'd7);

    // Pointer at 3 wraps: FU3 lands on port 0, FU0 on port 1
    tick();
    applyStimulus(4'b1001, {6'd63, 6'd0, 6'd0, 6'd5});
    @(negedge clk);
    checkOutput("wrap_ready", 32'(bus.fu_ready), 32'h9);
    tick();
    applyStimulus(4'b1111, {6'd23, 6'd22, 6'd21, 6'd20});
    @(negedge clk);
    checkOutput("wrap_id0", 32'(bus.rob_cpl_id[0]), 32'd63);
    checkOutput("wrap_id1", 32'(bus.rob_cpl_id[1]), 32'd5);
    checkOutput("ptr1_ready", 32'(bus.fu_ready), 32'h6);

    // Flush with everything valid
    tick();
    bus.flush = 1'b1;
    applyStimulus(4'b1111, {6'd23, 6'd32, 6'd31, 6'd20});
    @(negedge clk);
    checkOutput("flush_ready", 32'(bus.fu_ready), 32'h0);
    checkOutput("flush_stall_before", 32'(bus.stall_cycles), 32'd2);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid_after", 32'(bus.rob_cpl_valid), 32'h0);
    checkOutput("flush_stall_after", 32'(bus.stall_cycles), 32'd2);
    checkOutput("flush_ptr0_ready", 32'(bus.fu_ready), 32'h3);

    // Persistent oversubscription drives the counter into saturation
    guard = 0;
    while (mStall < 16'hFFFE && guard < 70000) begin
      tick();
      guard++;
    end
    @(negedge clk);
    checkOutput("stall_fffe", 32'(bus.stall_cycles), 32'hFFFE);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("stall_saturated", 32'(bus.stall_cycles), 32'hFFFF);
    checkOutput("stall_port_valid", 32'(bus.rob_cpl_valid), 32'h3);

    // Reset mid-operation, asserted together with flush
    tick();
    rst       = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(bus.fu_ready), 32'h0);
    tick();
    rst       = 1'b0;
    bus.flush = 1'b0;
    applyStimulus('0, '0);
    @(negedge clk);
    checkOutput("rst_valid_after", 32'(bus.rob_cpl_valid), 32'h0);
    checkOutput("rst_stall_after", 32'(bus.stall_cycles), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
